// File: rtl/twdl_seq_ctrl_if.sv
// Bundles the configuration, butterfly and twiddle-index signals of the twiddle sequencer.
// The err_cnt signal is present only when TWDL_SEQ_ERRCNT_EN is defined.
interface twdl_seq_ctrl_if #(
  parameter int wNum = 12,
  parameter int wQuo = 20,
  parameter int wBlk = 10
);
  logic            cfg_val;
  logic [2:0]      cfg_factor;
  logic [wNum-1:0] cfg_demontr;
  logic [wNum-1:0] cfg_bpb;
  logic [wBlk-1:0] cfg_nblk;
  logic [wQuo-1:0] cfg_q_step;
  logic [wNum-1:0] cfg_r_step;
  logic            bfly_val;

  logic [2:0]      factor;
  logic            twdl_sop;
  logic            twdl_val;
  logic [wNum-1:0] twdl_numrtr_1;
  logic [wNum-1:0] twdl_demontr;
  logic [wQuo-1:0] twdl_quotient;
  logic [wNum-1:0] twdl_remainder;
  logic            busy;
  logic            done;
  logic            cfg_err;
`ifdef TWDL_SEQ_ERRCNT_EN
  logic [7:0]      err_cnt;
`endif

  // Upstream side: drives configuration and butterfly strobes, observes the twiddle stream.
  modport master (
    output cfg_val, cfg_factor, cfg_demontr, cfg_bpb, cfg_nblk, cfg_q_step, cfg_r_step,
    output bfly_val,
    input  factor, twdl_sop, twdl_val, twdl_numrtr_1, twdl_demontr, twdl_quotient,
    input  twdl_remainder, busy, done, cfg_err
`ifdef TWDL_SEQ_ERRCNT_EN
    , input err_cnt
`endif
  );

  modport slave (
    input  cfg_val, cfg_factor, cfg_demontr, cfg_bpb, cfg_nblk, cfg_q_step, cfg_r_step,
    input  bfly_val,
    output factor, twdl_sop, twdl_val, twdl_numrtr_1, twdl_demontr, twdl_quotient,
    output twdl_remainder, busy, done, cfg_err
`ifdef TWDL_SEQ_ERRCNT_EN
    , output err_cnt
`endif
  );
endinterface

// File: rtl/twdl_seq_ctrl.sv
// Twiddle-stage sequencer: walks butterfly index j and computes j*2^20/D incrementally.
// Optional ignored-butterfly counter err_cnt is enabled by defining TWDL_SEQ_ERRCNT_EN.
module twdl_seq_ctrl #(
  parameter int wNum = 12,
  parameter int wQuo = 20,
  parameter int wBlk = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  twdl_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;

  state_t          state;
  logic [2:0]      factor_q;
  logic [wNum-1:0] dem_q;
  logic [wNum-1:0] bpb_q;
  logic [wNum-1:0] rstep_q;
  logic [wQuo-1:0] qstep_q;
  logic [wBlk-1:0] nblk_q;

  logic [wNum-1:0] j_cnt;
  logic [wNum-1:0] r_acc;
  logic [wQuo-1:0] q_acc;
  logic [wBlk-1:0] blk_cnt;

  logic            factor_ok;
  logic            accept;
  logic            last_j;
  logic            last_blk;
  logic [wNum:0]   r_sum;
  logic            r_wrap;
  logic [wNum-1:0] r_next;
  logic [wQuo-1:0] q_next;

  // The remainder sum is one bit wider so r + r_step never truncates before the compare with D.
  always_comb begin
    factor_ok = (bus.cfg_factor == 3'd2) || (bus.cfg_factor == 3'd3) ||
                (bus.cfg_factor == 3'd4) || (bus.cfg_factor == 3'd5);
    accept    = bus.bfly_val && ((state == ARMED) || (state == RUN));
    last_j    = (j_cnt == bpb_q - wNum'(1));
    last_blk  = (blk_cnt == nblk_q - wBlk'(1));
    r_sum     = {1'b0, r_acc} + {1'b0, rstep_q};
    r_wrap    = (r_sum >= {1'b0, dem_q});
    r_next    = r_wrap ? wNum'(r_sum - {1'b0, dem_q}) : r_sum[wNum-1:0];
    q_next    = q_acc + qstep_q + wQuo'(r_wrap);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      factor_q           <= '0;
      dem_q              <= '0;
      bpb_q              <= '0;
      rstep_q            <= '0;
      qstep_q            <= '0;
      nblk_q             <= '0;
      j_cnt              <= '0;
      r_acc              <= '0;
      q_acc              <= '0;
      blk_cnt            <= '0;
      bus.factor         <= '0;
      bus.twdl_sop       <= 1'b0;
      bus.twdl_val       <= 1'b0;
      bus.twdl_numrtr_1  <= '0;
      bus.twdl_demontr   <= '0;
      bus.twdl_quotient  <= '0;
      bus.twdl_remainder <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.cfg_err        <= 1'b0;
`ifdef TWDL_SEQ_ERRCNT_EN
      bus.err_cnt        <= '0;
`endif
    end else begin
      bus.twdl_val <= 1'b0;
      bus.twdl_sop <= 1'b0;
      bus.done     <= 1'b0;

      if (bus.bfly_val && !accept) begin
        bus.cfg_err <= 1'b1;
`ifdef TWDL_SEQ_ERRCNT_EN
        if (bus.err_cnt != 8'hFF) begin
          bus.err_cnt <= bus.err_cnt + 8'd1;
        end
`endif
      end

      case (state)
        IDLE: begin
          if (bus.cfg_val) begin
            if (factor_ok) begin
              factor_q <= bus.cfg_factor;
              dem_q    <= bus.cfg_demontr;
              bpb_q    <= bus.cfg_bpb;
              nblk_q   <= bus.cfg_nblk;
              qstep_q  <= bus.cfg_q_step;
              rstep_q  <= bus.cfg_r_step;
              j_cnt    <= '0;
              r_acc    <= '0;
              q_acc    <= '0;
              blk_cnt  <= '0;
              bus.busy <= 1'b1;
              state    <= ARMED;
            end else begin
              bus.cfg_err <= 1'b1;
            end
          end
        end

        // Emit the current indices, then step to the next butterfly or wrap at block end.
        ARMED, RUN: begin
          if (bus.bfly_val) begin
            bus.twdl_val       <= 1'b1;
            bus.twdl_sop       <= (state == ARMED);
            bus.twdl_numrtr_1  <= j_cnt;
            bus.twdl_quotient  <= q_acc;
            bus.twdl_remainder <= r_acc;
            bus.twdl_demontr   <= dem_q;
            bus.factor         <= factor_q;
            state              <= RUN;
            if (last_j) begin
              j_cnt   <= '0;
              r_acc   <= '0;
              q_acc   <= '0;
              blk_cnt <= blk_cnt + wBlk'(1);
              if (last_blk) begin
                bus.busy <= 1'b0;
                state    <= DONE;
              end
            end else begin
              j_cnt <= j_cnt + wNum'(1);
              r_acc <= r_next;
              q_acc <= q_next;
            end
          end
        end

        DONE: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twdl_seq_ctrl.sv
// Self-checking bench for twdl_seq_ctrl: vector tables for full frames plus directed corner sequences.
// Checks err_cnt saturation when TWDL_SEQ_ERRCNT_EN is defined.
module tb_twdl_seq_ctrl;

  typedef struct {
    logic        bfly;
    logic        cfgv;
    logic        val;
    logic        sop;
    logic        done;
    logic        busy;
    logic [11:0] num;
    logic [19:0] quo;
    logic [11:0] rem;
    logic [2:0]  fac;
    logic [11:0] dem;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  twdl_seq_ctrl_if bus ();

  twdl_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic bfly, logic cfgv, logic val, logic sop, logic done,
                              logic busy, int num, int quo, int rem, int fac, int dem);
    vec_t v;
    v.bfly = bfly;
    v.cfgv = cfgv;
    v.val  = val;
    v.sop  = sop;
    v.done = done;
    v.busy = busy;
    v.num  = 12'(num);
    v.quo  = 20'(quo);
    v.rem  = 12'(rem);
    v.fac  = 3'(fac);
    v.dem  = 12'(dem);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, return just after the rising edge.
  task automatic drive(input logic bfly, input logic cfgv);
    @(negedge clk);
    bus.bfly_val = bfly;
    bus.cfg_val  = cfgv;
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int fac, input int dem, input int bpb, input int nblk,
                           input int qs, input int rs);
    bus.cfg_factor  = 3'(fac);
    bus.cfg_demontr = 12'(dem);
    bus.cfg_bpb     = 12'(bpb);
    bus.cfg_nblk    = 10'(nblk);
    bus.cfg_q_step  = 20'(qs);
    bus.cfg_r_step  = 12'(rs);
    drive(1'b0, 1'b1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.bfly_val = 1'b0;
    bus.cfg_val  = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    drive(v.bfly, v.cfgv);
    checkOutput($sformatf("v%0d.twdl_val", idx), 32'(bus.twdl_val), 32'(v.val));
    checkOutput($sformatf("v%0d.twdl_sop", idx), 32'(bus.twdl_sop), 32'(v.sop));
    checkOutput($sformatf("v%0d.done", idx), 32'(bus.done), 32'(v.done));
    checkOutput($sformatf("v%0d.busy", idx), 32'(bus.busy), 32'(v.busy));
    checkOutput($sformatf("v%0d.numrtr", idx), 32'(bus.twdl_numrtr_1), 32'(v.num));
    checkOutput($sformatf("v%0d.quotient", idx), 32'(bus.twdl_quotient), 32'(v.quo));
    checkOutput($sformatf("v%0d.remainder", idx), 32'(bus.twdl_remainder), 32'(v.rem));
    checkOutput($sformatf("v%0d.factor", idx), 32'(bus.factor), 32'(v.fac));
    checkOutput($sformatf("v%0d.demontr", idx), 32'(bus.twdl_demontr), 32'(v.dem));
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end
    vecs.delete();
  endtask

  // D=12, bpb=4, nblk=2 frame with a configurable gap between butterflies.
  task automatic buildFrame12(input int gaps);
    int q12[4];
    int r12[4];
    logic last;
    q12 = '{0, 87381, 174762, 262144};
    r12 = '{0, 4, 8, 0};
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 4; j++) begin
        last = (b == 1) && (j == 3);
        vecs.push_back(mk(1, 0, 1, (b == 0) && (j == 0), 0, !last, j, q12[j], r12[j], 3, 12));
        if (last) begin
          vecs.push_back(mk(0, 0, 0, 0, 1, 0, j, q12[j], r12[j], 3, 12));
          vecs.push_back(mk(0, 0, 0, 0, 0, 0, j, q12[j], r12[j], 3, 12));
        end else begin
          for (int g = 0; g < gaps; g++) begin
            vecs.push_back(mk(0, 0, 0, 0, 0, 1, j, q12[j], r12[j], 3, 12));
          end
        end
      end
    end
  endtask

  initial begin
    int q5[5];
    q5 = '{0, 209715, 419430, 629145, 838860};
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.cfg_val  = 1'b0;
    bus.bfly_val = 1'b0;
    bus.cfg_factor  = '0;
    bus.cfg_demontr = '0;
    bus.cfg_bpb     = '0;
    bus.cfg_nblk    = '0;
    bus.cfg_q_step  = '0;
    bus.cfg_r_step  = '0;

    doReset();
    checkOutput("rst.twdl_val", 32'(bus.twdl_val), 32'd0);
    checkOutput("rst.busy", 32'(bus.busy), 32'd0);
    checkOutput("rst.cfg_err", 32'(bus.cfg_err), 32'd0);
    checkOutput("rst.quotient", 32'(bus.twdl_quotient), 32'd0);

    $display("[TB] back-to-back frame D=12");
    configure(3, 12, 4, 2, 87381, 4);
    checkOutput("cfg1.busy", 32'(bus.busy), 32'd1);
    checkOutput("cfg1.twdl_val", 32'(bus.twdl_val), 32'd0);
    buildFrame12(0);
    runTable();
    checkOutput("f1.cfg_err", 32'(bus.cfg_err), 32'd0);

    $display("[TB] gapped frame D=12");
    configure(3, 12, 4, 2, 87381, 4);
    checkOutput("cfg2.busy", 32'(bus.busy), 32'd1);
    buildFrame12(2);
    runTable();

    $display("[TB] illegal factor");
    configure(6, 12, 4, 2, 87381, 4);
    checkOutput("bad.cfg_err", 32'(bus.cfg_err), 32'd1);
    checkOutput("bad.busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      checkOutput($sformatf("bad%0d.twdl_val", i), 32'(bus.twdl_val), 32'd0);
      checkOutput($sformatf("bad%0d.busy", i), 32'(bus.busy), 32'd0);
    end
    drive(1'b0, 1'b0);
    checkOutput("bad.cfg_err_sticky", 32'(bus.cfg_err), 32'd1);

    $display("[TB] reset mid-frame");
    configure(3, 12, 4, 2, 87381, 4);
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0);
      checkOutput($sformatf("mid%0d.numrtr", j), 32'(bus.twdl_numrtr_1), 32'(j));
    end
    @(negedge clk);
    rst_n        = 1'b0;
    bus.bfly_val = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid.rst.twdl_val", 32'(bus.twdl_val), 32'd0);
    checkOutput("mid.rst.numrtr", 32'(bus.twdl_numrtr_1), 32'd0);
    checkOutput("mid.rst.quotient", 32'(bus.twdl_quotient), 32'd0);
    checkOutput("mid.rst.remainder", 32'(bus.twdl_remainder), 32'd0);
    checkOutput("mid.rst.demontr", 32'(bus.twdl_demontr), 32'd0);
    checkOutput("mid.rst.factor", 32'(bus.factor), 32'd0);
    checkOutput("mid.rst.busy", 32'(bus.busy), 32'd0);
    checkOutput("mid.rst.cfg_err", 32'(bus.cfg_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      checkOutput($sformatf("mid.nodone%0d", i), 32'(bus.done), 32'd0);
    end
    configure(3, 12, 4, 2, 87381, 4);
    drive(1'b1, 1'b0);
    checkOutput("restart.twdl_val", 32'(bus.twdl_val), 32'd1);
    checkOutput("restart.sop", 32'(bus.twdl_sop), 32'd1);
    checkOutput("restart.numrtr", 32'(bus.twdl_numrtr_1), 32'd0);
    checkOutput("restart.quotient", 32'(bus.twdl_quotient), 32'd0);
    doReset();

    $display("[TB] radix-5 frame with cfg_val during RUN");
    configure(5, 5, 5, 1, 209715, 1);
    bus.cfg_factor  = 3'd3;
    bus.cfg_demontr = 12'd12;
    bus.cfg_bpb     = 12'd4;
    bus.cfg_nblk    = 10'd2;
    bus.cfg_q_step  = 20'd87381;
    bus.cfg_r_step  = 12'd4;
    for (int j = 0; j < 5; j++) begin
      vecs.push_back(mk(1, (j == 2), 1, (j == 0), 0, (j != 4), j, q5[j], j, 5, 5));
    end
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 4, 838860, 4, 5, 5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4, 838860, 4, 5, 5));
    runTable();
    checkOutput("r5.cfg_err", 32'(bus.cfg_err), 32'd0);

    $display("[TB] butterflies while idle");
    doReset();
    drive(1'b1, 1'b0);
    checkOutput("idle.cfg_err", 32'(bus.cfg_err), 32'd1);
    checkOutput("idle.twdl_val", 32'(bus.twdl_val), 32'd0);
`ifdef TWDL_SEQ_ERRCNT_EN
    checkOutput("idle.err_cnt1", 32'(bus.err_cnt), 32'd1);
`endif
    for (int i = 1; i < 300; i++) begin
      drive(1'b1, 1'b0);
    end
`ifdef TWDL_SEQ_ERRCNT_EN
    checkOutput("idle.err_cnt_sat", 32'(bus.err_cnt), 32'd255);
`endif
    checkOutput("idle.busy", 32'(bus.busy), 32'd0);
    drive(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
